// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the bit serializer.
// Optional build macro: SER_PARITY_EN appends one even-parity bit to every word.
package ser_pkg;

    // Serializer control states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

`ifdef SER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Number of bit slots a single word occupies on the serial line.
    function automatic int ser_len(input int width);
`ifdef SER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    // Width of the bit counter needed to index every slot of a word.
    function automatic int ser_cnt_w(input int width);
        return $clog2(ser_len(width));
    endfunction

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = ser_cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-slot counter for the serializer: clears on load, counts up by one per
// increment and saturates at LEN-1, flagging the terminal (last) slot.
module ser_bit_counter #(
    parameter int LEN = 8,
    parameter int CW  = $clog2(LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins over increment; never advance past the last slot.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per clock, gapless when words arrive back to back.
// Optional build macro: SER_PARITY_EN appends an even-parity bit per word.
//
// Handshake: a word is taken at a posedge when in_valid && in_ready. in_ready
// is combinational, high in IDLE or while the last slot of the current word is
// on bit_out, and forced low while rst_n is low. The source must hold in_valid
// and data_in stable until the word is taken.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done
);

    localparam int LEN = ser_len(WIDTH);
    localparam int CW  = ser_cnt_w(WIDTH);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             bit_q, bit_d;
    logic             valid_q, valid_d;
    logic             par_bit;

    logic [CW-1:0]    cnt;
    logic             tc;
    logic             cnt_load;
    logic             cnt_inc;
    logic             accept;
    logic             do_load;

`ifdef SER_PARITY_EN
    logic             par_q, par_d;
    assign par_bit = par_q;
`else
    assign par_bit = IDLE_LEVEL;
`endif

    // Bit that leaves the word first, according to the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its head bit consumed, so the next bit becomes the head.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    ser_bit_counter #(
        .LEN (LEN),
        .CW  (CW)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .inc_i  (cnt_inc),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    // The counter parks at its last value in IDLE, so gate tc with the state.
    assign in_ready  = rst_n && ((state_q == IDLE) || tc);
    assign accept    = in_valid && in_ready;
    assign word_done = (state_q == SHIFT) && tc;
    assign bit_out   = bit_q;
    assign bit_valid = valid_q;

    // Next-state and datapath control: emit the next slot, reload, or go idle.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bit_d    = bit_q;
        valid_d  = valid_q;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        do_load  = 1'b0;
`ifdef SER_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                bit_d   = IDLE_LEVEL;
                valid_d = 1'b0;
                do_load = accept;
            end
            SHIFT: begin
                if (tc) begin
                    if (accept) begin
                        do_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        bit_d   = IDLE_LEVEL;
                        valid_d = 1'b0;
                    end
                end else begin
                    cnt_inc = 1'b1;
                    valid_d = 1'b1;
                    if (PARITY_EN && (cnt == CW'(WIDTH - 1))) begin
                        // All data bits are out; the parity slot follows.
                        bit_d = par_bit;
                    end else begin
                        bit_d   = head_bit(shreg_q);
                        shreg_d = advance(shreg_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                bit_d   = IDLE_LEVEL;
                valid_d = 1'b0;
            end
        endcase

        // A taken word puts its first bit on the line at the same edge.
        if (do_load) begin
            state_d  = SHIFT;
            bit_d    = head_bit(data_in);
            shreg_d  = advance(data_in);
            valid_d  = 1'b1;
            cnt_load = 1'b1;
`ifdef SER_PARITY_EN
            par_d    = ^data_in;
`endif
        end
    end

    // State, shift register and registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= IDLE_LEVEL;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
        end
    end

`ifdef SER_PARITY_EN
    // Parity of the word currently being shifted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule
